cache_ctrl_dm_wb: RTL



---
 rtl/cache_pkg.sv | 33 +++
 rtl/cache_line_array.sv | 73 +++++++
 rtl/cache_ctrl_dm_wb.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// ---------------------------------------------------------------------------
// cache_pkg
// Shared definitions for the direct-mapped write-back cache controller:
//   - state_e   : controller FSM states
//   - DEF_*     : default geometry used as parameter defaults
//   - TAG_W     : tag width for the default geometry
//   - LINES     : line count for the default geometry
//   - tagWidth  : derives tag width from address and index widths
// No ports; this file only carries types and constants.
// ---------------------------------------------------------------------------
package cache_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOOKUP,
      WRITEBACK,
      FILL,
      DONE
   } state_e;

   localparam int DEF_ADDR_W  = 8;
   localparam int DEF_DATA_W  = 8;
   localparam int DEF_INDEX_W = 2;

   // The tag is whatever address bits remain above the index field.
   function automatic int tagWidth(input int addrW, input int indexW);
      return addrW - indexW;
   endfunction

   localparam int TAG_W = tagWidth(DEF_ADDR_W, DEF_INDEX_W);
   localparam int LINES = 1 << DEF_INDEX_W;

endpackage

// File: rtl/cache_line_array.sv
// ---------------------------------------------------------------------------
// cache_line_array
// Storage for a direct-mapped cache: one valid bit, dirty bit, tag and data
// word per line, all selected by a single line index.
// Ports:
//   clk, rst              clock and synchronous active-high reset
//   index_i               line being read and (optionally) written
//   valid_o/dirty_o       combinational flag read of the selected line
//   tag_o/data_o          combinational tag/data read of the selected line
//   wr_data_en_i/_data_i  data word write
//   wr_tag_en_i/_tag_i    tag write
//   wr_flags_en_i         writes valid_i and dirty_i together
// Reset clears only the flags; tag and data contents are left as they are.
// ---------------------------------------------------------------------------
module cache_line_array
   import cache_pkg::*;
#(
   parameter int INDEX_W  = DEF_INDEX_W,
   parameter int TAG_BITS = TAG_W,
   parameter int DATA_W   = DEF_DATA_W
)(
   input  logic                clk,
   input  logic                rst,
   input  logic [INDEX_W-1:0]  index_i,
   output logic                valid_o,
   output logic                dirty_o,
   output logic [TAG_BITS-1:0] tag_o,
   output logic [DATA_W-1:0]   data_o,
   input  logic                wr_data_en_i,
   input  logic [DATA_W-1:0]   wr_data_i,
   input  logic                wr_tag_en_i,
   input  logic [TAG_BITS-1:0] wr_tag_i,
   input  logic                wr_flags_en_i,
   input  logic                wr_valid_i,
   input  logic                wr_dirty_i
);

   localparam int NUM_LINES = 1 << INDEX_W;

   logic [NUM_LINES-1:0] valid_q;
   logic [NUM_LINES-1:0] dirty_q;
   logic [TAG_BITS-1:0]  tag_q  [NUM_LINES];
   logic [DATA_W-1:0]    data_q [NUM_LINES];

   // Flag bits: reset invalidates every line, otherwise a flag write updates
   // the selected line only.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
         dirty_q <= '0;
      end else if (wr_flags_en_i) begin
         valid_q[index_i] <= wr_valid_i;
         dirty_q[index_i] <= wr_dirty_i;
      end
   end

   // Tag and data carry no reset; a cleared valid bit makes stale contents
   // unreachable.
   always_ff @(posedge clk) begin
      if (wr_tag_en_i) begin
         tag_q[index_i] <= wr_tag_i;
      end
      if (wr_data_en_i) begin
         data_q[index_i] <= wr_data_i;
      end
   end

   assign valid_o = valid_q[index_i];
   assign dirty_o = dirty_q[index_i];
   assign tag_o   = tag_q[index_i];
   assign data_o  = data_q[index_i];

endmodule

// File: rtl/cache_ctrl_dm_wb.sv
// ---------------------------------------------------------------------------
// cache_ctrl_dm_wb
// Direct-mapped, write-back, write-allocate cache controller, one word per
// line. The CPU side uses a start/read_op strobe and a one-cycle finish_flag
// pulse; the memory side is a req/ack port of arbitrary latency used for
// dirty-line writebacks and line fills.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start, read_op           request strobe and direction (1 = read)
//   in_address, in_data      request address and write data
//   out_data                 read result, held until the next read completes
//   finish_flag, hit_flag    completion pulse and hit indication
//   busy                     request in progress
//   mem_req, mem_we          memory request (held until ack) and direction
//   mem_addr, mem_wdata      memory address and writeback data
//   mem_rdata, mem_ack       fill data and one-cycle acknowledge
// All outputs come straight from registers.
// ---------------------------------------------------------------------------
module cache_ctrl_dm_wb
   import cache_pkg::*;
#(
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int DATA_W  = DEF_DATA_W,
   parameter int INDEX_W = DEF_INDEX_W
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              read_op,
   input  logic [ADDR_W-1:0] in_address,
   input  logic [DATA_W-1:0] in_data,
   output logic [DATA_W-1:0] out_data,
   output logic              finish_flag,
   output logic              hit_flag,
   output logic              busy,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack
);

   localparam int TAG_BITS = tagWidth(ADDR_W, INDEX_W);

   state_e              state_q;
   logic                read_op_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [DATA_W-1:0]   out_data_q;
   logic                finish_q;
   logic                hit_q;
   logic                busy_q;
   logic                mem_req_q;
   logic                mem_we_q;
   logic [ADDR_W-1:0]   mem_addr_q;
   logic [DATA_W-1:0]   mem_wdata_q;

   logic [INDEX_W-1:0]  req_index;
   logic [TAG_BITS-1:0] req_tag;
   logic                line_valid;
   logic                line_dirty;
   logic [TAG_BITS-1:0] line_tag;
   logic [DATA_W-1:0]   line_data;
   logic                lookup_hit;
   logic                fill_done;

   logic                wr_data_en;
   logic [DATA_W-1:0]   wr_data;
   logic                wr_tag_en;
   logic                wr_flags_en;
   logic                wr_valid;
   logic                wr_dirty;

   assign req_index  = addr_q[INDEX_W-1:0];
   assign req_tag    = addr_q[ADDR_W-1:INDEX_W];
   assign lookup_hit = line_valid && (line_tag == req_tag);
   // An ack only counts while our own request is actually outstanding.
   assign fill_done  = (state_q == FILL) && mem_req_q && mem_ack;

   cache_line_array #(
      .INDEX_W  (INDEX_W),
      .TAG_BITS (TAG_BITS),
      .DATA_W   (DATA_W)
   ) u_lines (
      .clk           (clk),
      .rst           (rst),
      .index_i       (req_index),
      .valid_o       (line_valid),
      .dirty_o       (line_dirty),
      .tag_o         (line_tag),
      .data_o        (line_data),
      .wr_data_en_i  (wr_data_en),
      .wr_data_i     (wr_data),
      .wr_tag_en_i   (wr_tag_en),
      .wr_tag_i      (req_tag),
      .wr_flags_en_i (wr_flags_en),
      .wr_valid_i    (wr_valid),
      .wr_dirty_i    (wr_dirty)
   );

   // Line updates happen in two places: a write hit during LOOKUP, and the
   // acknowledged fill. A write miss allocates the line and then overlays
   // the CPU's word, so the fill completes with the line already dirty.
   always_comb begin
      wr_data_en  = 1'b0;
      wr_data     = wdata_q;
      wr_tag_en   = 1'b0;
      wr_flags_en = 1'b0;
      wr_valid    = 1'b1;
      wr_dirty    = 1'b1;
      if (state_q == LOOKUP && lookup_hit && !read_op_q) begin
         wr_data_en  = 1'b1;
         wr_flags_en = 1'b1;
      end else if (fill_done) begin
         wr_data_en  = 1'b1;
         wr_tag_en   = 1'b1;
         wr_flags_en = 1'b1;
         wr_data     = read_op_q ? mem_rdata : wdata_q;
         wr_dirty    = !read_op_q;
      end
   end

   // Controller FSM with registered outputs. finish_flag is raised on the
   // edge that leaves DONE, so it is high in the first IDLE cycle, which is
   // also the cycle in which the next start can be accepted. Between a
   // writeback and the following fill, mem_req spends one cycle low in FILL
   // before being re-raised, so two transactions never merge.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         read_op_q   <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         out_data_q  <= '0;
         finish_q    <= 1'b0;
         hit_q       <= 1'b0;
         busy_q      <= 1'b0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         finish_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  read_op_q <= read_op;
                  addr_q    <= in_address;
                  wdata_q   <= in_data;
                  busy_q    <= 1'b1;
                  state_q   <= LOOKUP;
               end
            end
            LOOKUP: begin
               if (lookup_hit) begin
                  hit_q <= 1'b1;
                  if (read_op_q) begin
                     out_data_q <= line_data;
                  end
                  state_q <= DONE;
               end else if (line_valid && line_dirty) begin
                  hit_q       <= 1'b0;
                  mem_req_q   <= 1'b1;
                  mem_we_q    <= 1'b1;
                  mem_addr_q  <= {line_tag, req_index};
                  mem_wdata_q <= line_data;
                  state_q     <= WRITEBACK;
               end else begin
                  hit_q      <= 1'b0;
                  mem_req_q  <= 1'b1;
                  mem_we_q   <= 1'b0;
                  mem_addr_q <= addr_q;
                  state_q    <= FILL;
               end
            end
            WRITEBACK: begin
               if (mem_req_q && mem_ack) begin
                  mem_req_q <= 1'b0;
                  state_q   <= FILL;
               end
            end
            FILL: begin
               if (!mem_req_q) begin
                  mem_req_q  <= 1'b1;
                  mem_we_q   <= 1'b0;
                  mem_addr_q <= addr_q;
               end else if (mem_ack) begin
                  mem_req_q <= 1'b0;
                  if (read_op_q) begin
                     out_data_q <= mem_rdata;
                  end
                  state_q <= DONE;
               end
            end
            DONE: begin
               finish_q <= 1'b1;
               busy_q   <= 1'b0;
               state_q  <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign out_data    = out_data_q;
   assign finish_flag = finish_q;
   assign hit_flag    = hit_q;
   assign busy        = busy_q;
   assign mem_req     = mem_req_q;
   assign mem_we      = mem_we_q;
   assign mem_addr    = mem_addr_q;
   assign mem_wdata   = mem_wdata_q;

endmodule
